d_mem_latency_controller: RTL

//  Data-memory stage directly downstream of the core's memory interface: consumes d_mem_* requests
//  and produces d_mem_* responses. Holds a 2^D_ADDRESS_BITS x DATA_WIDTH word array behind a

---
 rtl/d_mem_latency_controller.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/d_mem_latency_controller.sv
// Word-addressed data memory behind a ready/valid port; responses arrive LATENCY cycles after accept.
// ready drops while an access is in flight and rises again in its response cycle; requests seen while ready=0 are ignored.
module d_mem_latency_controller #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDRESS_BITS    = 32,
    parameter int D_ADDRESS_BITS  = 14,
    parameter int LATENCY         = 1,
    parameter int SCAN_CYCLES_MIN = 0,
    parameter int SCAN_CYCLES_MAX = 1000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    d_mem_read,
    input  logic                    d_mem_write,
    input  logic [ADDRESS_BITS-1:0] d_mem_address_in,
    input  logic [DATA_WIDTH-1:0]   d_mem_data_in,
    output logic [DATA_WIDTH-1:0]   d_mem_data_out,
    output logic [ADDRESS_BITS-1:0] d_mem_address_out,
    output logic                    d_mem_valid,
    output logic                    d_mem_ready,
    input  logic                    scan
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam int          WORDS   = 1 << D_ADDRESS_BITS;
    localparam logic [31:0] SCAN_LO = SCAN_CYCLES_MIN;
    localparam logic [31:0] SCAN_HI = SCAN_CYCLES_MAX;

    state_t                    state_q, state_d;
    logic [3:0]                cnt_q, cnt_d;
    logic                      pend_rd_q, pend_rd_d;
    logic [DATA_WIDTH-1:0]     pend_dat_q, pend_dat_d;
    logic [ADDRESS_BITS-1:0]   pend_addr_q, pend_addr_d;
    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic [ADDRESS_BITS-1:0]   addr_q, addr_d;
    logic                      valid_q, valid_d;
    logic                      ready_q, ready_d;
    logic [31:0]               cycle_q;
    logic [DATA_WIDTH-1:0]     mem [WORDS];
    logic [D_ADDRESS_BITS-1:0] idx;
    logic                      accept;
    logic                      acc_rd;

    // Byte-offset bits and anything above the array size are dropped, so addresses alias.
    assign idx    = d_mem_address_in[D_ADDRESS_BITS+1:2];
    assign accept = ready_q & (d_mem_read | d_mem_write);
    assign acc_rd = accept & d_mem_read & ~d_mem_write;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_rd_d   = pend_rd_q;
        pend_dat_d  = pend_dat_q;
        pend_addr_d = pend_addr_q;
        data_d      = data_q;
        addr_d      = addr_q;
        valid_d     = 1'b0;
        ready_d     = ready_q;
        case (state_q)
            WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    ready_d = 1'b1;
                    if (pend_rd_q) begin
                        valid_d = 1'b1;
                        data_d  = pend_dat_q;
                        addr_d  = pend_addr_q;
                    end
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    ready_d = 1'b0;
                end
            end
            default: begin
                ready_d = 1'b1;
                state_d = IDLE;
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        if (acc_rd) begin
                            valid_d = 1'b1;
                            data_d  = mem[idx];
                            addr_d  = d_mem_address_in;
                        end
                    end else begin
                        state_d     = WAIT;
                        cnt_d       = 4'(LATENCY - 1);
                        ready_d     = 1'b0;
                        pend_rd_d   = acc_rd;
                        pend_dat_d  = mem[idx];
                        pend_addr_d = d_mem_address_in;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pend_rd_q   <= 1'b0;
            pend_dat_q  <= '0;
            pend_addr_q <= '0;
            data_q      <= '0;
            addr_q      <= '0;
            valid_q     <= 1'b0;
            ready_q     <= 1'b0;
            cycle_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_rd_q   <= pend_rd_d;
            pend_dat_q  <= pend_dat_d;
            pend_addr_q <= pend_addr_d;
            data_q      <= data_d;
            addr_q      <= addr_d;
            valid_q     <= valid_d;
            ready_q     <= ready_d;
            cycle_q     <= cycle_q + 32'd1;
        end
    end

    // Array contents deliberately survive reset.
    always_ff @(posedge clock) begin
        if (!reset && accept && d_mem_write) begin
            mem[idx] <= d_mem_data_in;
        end
    end

    assign d_mem_data_out    = data_q;
    assign d_mem_address_out = addr_q;
    assign d_mem_valid       = valid_q;
    assign d_mem_ready       = ready_q;

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (scan && ((cycle_q - SCAN_LO) <= (SCAN_HI - SCAN_LO))) begin
            $display("dmem cyc=%0d state=%s ready=%b valid=%b addr=%h data=%h",
                     cycle_q, state_q.name(), ready_q, valid_q, addr_q, data_q);
        end
    end
`endif
endmodule
